// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the async-FIFO read-side stream consumer.
`ifndef DSIZE
`define DSIZE 8
`endif

package fifo_rd_pkg;

  localparam int unsigned DATA_W    = `DSIZE;
  localparam int unsigned BUF_DEPTH = 2;

  typedef logic [1:0] occ_t;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Valid/ready stream with packet framing, as presented to the downstream consumer.
interface fifo_rd_stream_if #(
  parameter int unsigned DSIZE = `DSIZE
);

  logic             m_valid;
  logic             m_ready;
  logic [DSIZE-1:0] m_data;
  logic             m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);

endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry in-order buffer: slot0 is the presented head, slot1 absorbs one stalled word.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output occ_t         occ,
  output logic         valid,
  output logic [W-1:0] head
);

  occ_t         occ_q, occ_d;
  logic         valid_q, valid_d;
  logic [W-1:0] slot0_q, slot0_d;
  logic [W-1:0] slot1_q, slot1_d;

  // Push is only offered below BUF_DEPTH and pop only while valid, so push+pop implies occ=1.
  always_comb begin
    occ_d   = occ_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == occ_t'(0)) slot0_d = push_data;
        else                    slot1_d = push_data;
        occ_d = occ_q + occ_t'(1);
      end
      2'b01: begin
        slot0_d = slot1_q;
        occ_d   = occ_q - occ_t'(1);
      end
      2'b11:   slot0_d = push_data;
      default: ;
    endcase
    valid_d = (occ_d != occ_t'(0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q   <= '0;
      valid_q <= 1'b0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      occ_q   <= occ_d;
      valid_q <= valid_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  assign occ   = occ_q;
  assign valid = valid_q;
  assign head  = slot0_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side FIFO consumer: pops into a 2-entry buffer and re-presents words as a framed
// registered stream with pop/packet counters. rinc never depends on m_ready.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DSIZE   = `DSIZE,
  parameter int unsigned PKT_LEN = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  en,
  input  logic                  rempty,
  input  logic [DSIZE-1:0]      rdata,
  output logic                  rinc,
  fifo_rd_stream_if.master      m,
  output logic [CNT_W-1:0]      pop_count,
  output logic [CNT_W-1:0]      pkt_count
);

  localparam int unsigned BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(PKT_LEN - 1);

  occ_t             occ;
  logic             valid;
  logic [DSIZE:0]   head;
  logic             consume;
  logic             tag_last;

  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]  pop_count_q, pop_count_d;
  logic [CNT_W-1:0]  pkt_count_q, pkt_count_d;

  assign rinc     = rrst_n & en & ~rempty & (occ < occ_t'(BUF_DEPTH));
  assign consume  = valid & m.m_ready;
  assign tag_last = (beat_cnt_q == BEAT_MAX);

  fifo_rd_skid #(.W(DSIZE + 1)) u_skid (
    .clk       (rclk),
    .rst_n     (rrst_n),
    .push      (rinc),
    .push_data ({tag_last, rdata}),
    .pop       (consume),
    .occ       (occ),
    .valid     (valid),
    .head      (head)
  );

  // Framing position advances only on pops, so it holds while en is low.
  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    pop_count_d = pop_count_q + CNT_W'(rinc);
    pkt_count_d = pkt_count_q + CNT_W'(consume & head[DSIZE]);
    if (rinc) beat_cnt_d = tag_last ? '0 : beat_cnt_q + BEAT_W'(1);
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      beat_cnt_q  <= '0;
      pop_count_q <= '0;
      pkt_count_q <= '0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      pop_count_q <= pop_count_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign m.m_valid = valid;
  assign m.m_last  = head[DSIZE];
  assign m.m_data  = head[DSIZE-1:0];
  assign pop_count = pop_count_q;
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench: FIFO model + scoreboard driving two instances (PKT_LEN=8/CNT_W=16 and PKT_LEN=1/CNT_W=4).
module tb_fifo_rd_stream;
  import fifo_rd_pkg::*;

  logic        rclk = 1'b0;
  logic        rrst_n;
  logic        en;
  logic        rempty;
  logic [7:0]  rdata;
  logic        m_ready;
  logic        rinc0, rinc1;
  logic [15:0] popc0, pktc0;
  logic [3:0]  popc1, pktc1;

  fifo_rd_stream_if #(.DSIZE(8)) s0 ();
  fifo_rd_stream_if #(.DSIZE(8)) s1 ();
  assign s0.m_ready = m_ready;
  assign s1.m_ready = m_ready;

  fifo_rd_stream #(.DSIZE(8), .PKT_LEN(8), .CNT_W(16)) dut0 (
    .rclk(rclk), .rrst_n(rrst_n), .en(en), .rempty(rempty), .rdata(rdata),
    .rinc(rinc0), .m(s0), .pop_count(popc0), .pkt_count(pktc0)
  );

  fifo_rd_stream #(.DSIZE(8), .PKT_LEN(1), .CNT_W(4)) dut1 (
    .rclk(rclk), .rrst_n(rrst_n), .en(en), .rempty(rempty), .rdata(rdata),
    .rinc(rinc1), .m(s1), .pop_count(popc1), .pkt_count(pktc1)
  );

  always #5 rclk = ~rclk;

  logic [7:0] fifo[$];
  beat_t      sb[$];
  int mocc, tag_idx, exp_pop, exp_pkt0, exp_pkt1, rinc_cycles;
  int n_cmp, n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    rempty = (fifo.size() == 0);
    rdata  = rempty ? 8'($urandom) : fifo[0];
  endtask

  task automatic push_word(input logic [7:0] d);
    beat_t b;
    b.last = ((tag_idx % 8) == 7);
    b.data = d;
    fifo.push_back(d);
    sb.push_back(b);
    tag_idx++;
    refresh();
  endtask

  // One clock: check outputs against the model before the edge, then advance the model.
  task automatic step();
    logic  exp_rinc, cons;
    beat_t h;
    int    inc0, inc1;
    #1;
    exp_rinc = rrst_n && en && (fifo.size() > 0) && (mocc < 2);
    cons     = rrst_n && (mocc != 0) && m_ready;
    inc0 = 0;
    inc1 = 0;
    chk("rinc0", 32'(rinc0), 32'(exp_rinc));
    chk("rinc1", 32'(rinc1), 32'(exp_rinc));
    chk("m_valid0", 32'(s0.m_valid), 32'(mocc != 0));
    chk("m_valid1", 32'(s1.m_valid), 32'(mocc != 0));
    if (mocc != 0) begin
      h = sb[0];
      chk("m_data0", 32'(s0.m_data), 32'(h.data));
      chk("m_last0", 32'(s0.m_last), 32'(h.last));
      chk("m_data1", 32'(s1.m_data), 32'(h.data));
      chk("m_last1", 32'(s1.m_last), 32'd1);
      if (cons) begin
        void'(sb.pop_front());
        inc0 = int'(h.last);
        inc1 = 1;
      end
    end
    chk("pop_count0", 32'(popc0), 32'(exp_pop[15:0]));
    chk("pop_count1", 32'(popc1), 32'(exp_pop[3:0]));
    chk("pkt_count0", 32'(pktc0), 32'(exp_pkt0[15:0]));
    chk("pkt_count1", 32'(pktc1), 32'(exp_pkt1[3:0]));
    @(posedge rclk);
    #1;
    if (exp_rinc) begin
      void'(fifo.pop_front());
      exp_pop++;
      rinc_cycles++;
    end
    exp_pkt0 += inc0;
    exp_pkt1 += inc1;
    mocc = mocc + int'(exp_rinc) - int'(cons);
    refresh();
  endtask

  task automatic do_reset();
    rrst_n = 1'b0;
    #1;
    fifo.delete();
    sb.delete();
    mocc = 0; tag_idx = 0; exp_pop = 0; exp_pkt0 = 0; exp_pkt1 = 0;
    refresh();
    #1;
    chk("rst_rinc0", 32'(rinc0), 32'd0);
    chk("rst_valid0", 32'(s0.m_valid), 32'd0);
    chk("rst_data0", 32'(s0.m_data), 32'd0);
    chk("rst_last0", 32'(s0.m_last), 32'd0);
    chk("rst_popc0", 32'(popc0), 32'd0);
    chk("rst_pktc0", 32'(pktc0), 32'd0);
    chk("rst_valid1", 32'(s1.m_valid), 32'd0);
    chk("rst_popc1", 32'(popc1), 32'd0);
    @(posedge rclk);
    @(posedge rclk);
    @(negedge rclk);
    rrst_n = 1'b1;
    @(posedge rclk);
    #1;
  endtask

  task automatic drain(input int maxc);
    for (int i = 0; i < maxc && sb.size() > 0; i++) step();
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; rinc_cycles = 0;
    en = 1'b0; m_ready = 1'b0; rrst_n = 1'b0;
    fifo.delete();
    refresh();

    // Single word
    do_reset();
    en = 1'b1; m_ready = 1'b1;
    push_word(8'hA5);
    step();
    chk("t1_data", 32'(s0.m_data), 32'hA5);
    step();
    step();
    chk("t1_popc", 32'(popc0), 32'd1);

    // 16-word stream, two packets
    do_reset();
    en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 16; i++) push_word(8'(8'h10 + i));
    rinc_cycles = 0;
    for (int i = 0; i < 18; i++) step();
    chk("t2_rinc_cycles", 32'(rinc_cycles), 32'd16);
    chk("t2_pktc0", 32'(pktc0), 32'd2);
    drain(10);

    // Stall with a full FIFO
    do_reset();
    en = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 10; i++) push_word(8'(8'h30 + i));
    for (int i = 0; i < 10; i++) step();
    chk("t3_popc", 32'(popc0), 32'd2);
    chk("t3_hold", 32'(s0.m_data), 32'h30);
    m_ready = 1'b1;
    drain(40);

    // en dropped with two words buffered
    do_reset();
    en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_word(8'(8'h50 + i));
    step();
    step();
    m_ready = 1'b0;
    step();
    chk("t4_popc3", 32'(popc0), 32'd3);
    en = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("t4_popc_hold", 32'(popc0), 32'd3);
    chk("t4_empty", 32'(s0.m_valid), 32'd0);
    en = 1'b1;
    drain(30);
    chk("t4_pktc0", 32'(pktc0), 32'd1);

    // Reset mid-burst at occ=2, then framing restarts
    do_reset();
    en = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_word(8'(8'h70 + i));
    for (int i = 0; i < 3; i++) step();
    chk("t5_full", 32'(s0.m_valid), 32'd1);
    do_reset();
    en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_word(8'(8'h90 + i));
    drain(30);
    chk("t5_pktc0", 32'(pktc0), 32'd1);

    // Narrow counters wrap; PKT_LEN=1 marks every beat last
    do_reset();
    en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 17; i++) push_word(8'(8'hC0 + i));
    drain(40);
    step();
    chk("t6_popc1", 32'(popc1), 32'd1);
    chk("t6_pktc1", 32'(pktc1), 32'd1);
    chk("t6_popc0", 32'(popc0), 32'd17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
